// File: rtl/stage5_dict_update_serialize_pkg.sv
// Shared constants for stage 5: message geometry, dictionary field layout and reset values,
// FSM encoding and the pending-lane priority helper.
package stage5_dict_update_serialize_pkg;

  localparam int MSG_W = 280;
  localparam int FLD_W = 8;

  // PID, MC and MT sit back to back at the top of every decoded message
  localparam int PID_HI = MSG_W - 1;
  localparam int MC_HI  = MSG_W - 1 - FLD_W;
  localparam int MT_HI  = MSG_W - 1 - 2 * FLD_W;

  localparam logic [FLD_W-1:0] PID1_RST = 8'h00;
  localparam logic [FLD_W-1:0] MC1_RST  = 8'h00;
  localparam logic [FLD_W-1:0] MT1_RST  = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Isolates the lowest set bit, i.e. the next lane to emit
  function automatic logic [2:0] lowest_lane(input logic [2:0] p);
    return p & (~p + 3'd1);
  endfunction

endpackage

// File: rtl/stage5_dict_update_serialize_if.sv
// Bundle input and serial output handshakes between stage 4, stage 5 and stage 6.
interface stage5_dict_update_serialize_if #(
  parameter int MSG_W = 280
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_lane_vld;
  logic [MSG_W-1:0] message_1;
  logic [MSG_W-1:0] message_2;
  logic [MSG_W-1:0] message_3;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_message;
  logic [1:0]       out_lane;

  modport slave (
    input  in_valid, in_lane_vld, message_1, message_2, message_3, out_ready,
    output in_ready, out_valid, out_message, out_lane
  );

  modport master (
    output in_valid, in_lane_vld, message_1, message_2, message_3, out_ready,
    input  in_ready, out_valid, out_message, out_lane
  );

endinterface

// File: rtl/stage5_dict_update_serialize_field_dict.sv
// FAST copy-operator dictionary (PID1/MC1/MT1); a template clear outranks a bundle update.
module stage5_dict_update_serialize_field_dict #(
  parameter int               FLD_W    = 8,
  parameter logic [FLD_W-1:0] PID1_RST = '0,
  parameter logic [FLD_W-1:0] MC1_RST  = '0,
  parameter logic [FLD_W-1:0] MT1_RST  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [FLD_W-1:0] upd_pid,
  input  logic [FLD_W-1:0] upd_mc,
  input  logic [FLD_W-1:0] upd_mt,
  output logic [FLD_W-1:0] field_PID1,
  output logic [FLD_W-1:0] field_MC1,
  output logic [FLD_W-1:0] field_MT1
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_PID1 <= PID1_RST;
      field_MC1  <= MC1_RST;
      field_MT1  <= MT1_RST;
    end else if (clr) begin
      field_PID1 <= PID1_RST;
      field_MC1  <= MC1_RST;
      field_MT1  <= MT1_RST;
    end else if (upd) begin
      field_PID1 <= upd_pid;
      field_MC1  <= upd_mc;
      field_MT1  <= upd_mt;
    end
  end

endmodule

// File: rtl/stage5_dict_update_serialize.sv
// Stage 5: owns the FAST dictionary fed back to stage 4 and serialises each accepted
// 3-lane bundle into one valid/ready message stream for stage 6.
module stage5_dict_update_serialize
  import stage5_dict_update_serialize_pkg::*;
#(
  parameter int               MSG_W    = stage5_dict_update_serialize_pkg::MSG_W,
  parameter int               FLD_W    = stage5_dict_update_serialize_pkg::FLD_W,
  parameter logic [FLD_W-1:0] PID1_RST = stage5_dict_update_serialize_pkg::PID1_RST,
  parameter logic [FLD_W-1:0] MC1_RST  = stage5_dict_update_serialize_pkg::MC1_RST,
  parameter logic [FLD_W-1:0] MT1_RST  = stage5_dict_update_serialize_pkg::MT1_RST
) (
  input  logic                           clk,
  input  logic                           rst_n,
  stage5_dict_update_serialize_if.slave  bus,
  input  logic                           dict_clr,
  output logic [FLD_W-1:0]               field_PID1,
  output logic [FLD_W-1:0]               field_MC1,
  output logic [FLD_W-1:0]               field_MT1,
  output logic [31:0]                    out_msg_cnt
);

  state_t             state_q, state_d;
  logic [2:0]         pend_q, pend_d, low_bit;
  logic [MSG_W-1:0]   hold_1, hold_2, hold_3;
  logic               accept, fire, upd;
  logic [3*FLD_W-1:0] head;

  assign low_bit = lowest_lane(pend_q);
  assign accept  = bus.in_valid & bus.in_ready;
  assign fire    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A new bundle can only land while draining when its last lane leaves this same cycle
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d = bus.in_lane_vld;
    end else if (fire) begin
      pend_d = pend_q & ~low_bit;
    end
    state_d = (pend_d != 3'b000) ? DRAIN : IDLE;
  end

  always_comb begin
    bus.out_valid   = (state_q == DRAIN);
    bus.in_ready    = (state_q == IDLE) | (bus.out_ready & $onehot(pend_q));
    bus.out_lane    = 2'd0;
    bus.out_message = '0;
    case (low_bit)
      3'b001:  begin bus.out_lane = 2'd1; bus.out_message = hold_1; end
      3'b010:  begin bus.out_lane = 2'd2; bus.out_message = hold_2; end
      3'b100:  begin bus.out_lane = 2'd3; bus.out_message = hold_3; end
      default: begin bus.out_lane = 2'd0; bus.out_message = '0;     end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_1 <= '0;
      hold_2 <= '0;
      hold_3 <= '0;
    end else if (accept) begin
      hold_1 <= bus.message_1;
      hold_2 <= bus.message_2;
      hold_3 <= bus.message_3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_msg_cnt <= 32'd0;
    end else if (fire) begin
      out_msg_cnt <= out_msg_cnt + 32'd1;
    end
  end

  // The highest-index real lane is the most recent message, so its fields win
  always_comb begin
    head = bus.message_1[MSG_W-1 -: 3*FLD_W];
    if (bus.in_lane_vld[2]) begin
      head = bus.message_3[MSG_W-1 -: 3*FLD_W];
    end else if (bus.in_lane_vld[1]) begin
      head = bus.message_2[MSG_W-1 -: 3*FLD_W];
    end
  end

  assign upd = accept & (bus.in_lane_vld != 3'b000);

  stage5_dict_update_serialize_field_dict #(
    .FLD_W    (FLD_W),
    .PID1_RST (PID1_RST),
    .MC1_RST  (MC1_RST),
    .MT1_RST  (MT1_RST)
  ) u_dict (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (dict_clr),
    .upd        (upd),
    .upd_pid    (head[3*FLD_W-1 -: FLD_W]),
    .upd_mc     (head[2*FLD_W-1 -: FLD_W]),
    .upd_mt     (head[FLD_W-1 -: FLD_W]),
    .field_PID1 (field_PID1),
    .field_MC1  (field_MC1),
    .field_MT1  (field_MT1)
  );

endmodule

// File: tb/tb_stage5_dict_update_serialize.sv
// Bench for stage 5: a queue/dictionary model checked every cycle, directed scenarios with
// literal expectations, then a randomized bundle/backpressure phase.
module tb_stage5_dict_update_serialize;

  localparam int MSG_W = 280;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dict_clr = 1'b0;
  logic [7:0]  field_PID1, field_MC1, field_MT1;
  logic [31:0] out_msg_cnt;

  stage5_dict_update_serialize_if #(.MSG_W(MSG_W)) bus ();

  stage5_dict_update_serialize #(.MSG_W(MSG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dict_clr    (dict_clr),
    .field_PID1  (field_PID1),
    .field_MC1   (field_MC1),
    .field_MT1   (field_MT1),
    .out_msg_cnt (out_msg_cnt)
  );

  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [MSG_W-1:0] q_msg [$];
  logic [1:0]       q_lane [$];
  logic [7:0]       m_pid = 8'h00, m_mc = 8'h00, m_mt = 8'h00;
  logic [31:0]      m_cnt = 32'd0;

  task automatic checkOutput(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic [7:0] pid, input logic [7:0] mc, input logic [7:0] mt);
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    r[279:256] = {pid, mc, mt};
    return r[MSG_W-1:0];
  endfunction

  task automatic applyStimulus(input logic v, input logic [2:0] mask, input logic [MSG_W-1:0] m1,
                               input logic [MSG_W-1:0] m2, input logic [MSG_W-1:0] m3, input logic clr);
    bus.in_valid    = v;
    bus.in_lane_vld = mask;
    bus.message_1   = m1;
    bus.message_2   = m2;
    bus.message_3   = m3;
    dict_clr        = clr;
  endtask

  // Holds the bundle until accepted; returns at posedge+1 of the cycle after acceptance
  task automatic sendBundle(input logic [2:0] mask, input logic [MSG_W-1:0] m1, input logic [MSG_W-1:0] m2,
                            input logic [MSG_W-1:0] m3, input logic clr, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    applyStimulus(1'b1, mask, m1, m2, m3, clr);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      waited++;
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    checkOutput("accept_within_bound", MSG_W'(ok), MSG_W'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    dict_clr = 1'b0;
  endtask

  task automatic waitIdle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.out_valid) begin ok = 1'b1; break; end
    end
    checkOutput("drain_within_bound", MSG_W'(ok), MSG_W'(1));
    @(posedge clk); #1;
  endtask

  // Reference model: a FIFO of lanes still owed downstream plus the current dictionary
  initial begin
    logic exp_ready, fire, accept;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_msg.delete();
        q_lane.delete();
        m_pid = 8'h00; m_mc = 8'h00; m_mt = 8'h00;
        m_cnt = 32'd0;
      end else begin
        exp_ready = (q_msg.size() == 0) || (bus.out_ready && q_msg.size() == 1);
        checkOutput("m_out_valid", MSG_W'(bus.out_valid), MSG_W'(q_msg.size() != 0));
        checkOutput("m_in_ready", MSG_W'(bus.in_ready), MSG_W'(exp_ready));
        if (q_msg.size() != 0) begin
          checkOutput("m_out_message", bus.out_message, q_msg[0]);
          checkOutput("m_out_lane", MSG_W'(bus.out_lane), MSG_W'(q_lane[0]));
        end
        checkOutput("m_dict", MSG_W'({field_PID1, field_MC1, field_MT1}), MSG_W'({m_pid, m_mc, m_mt}));
        checkOutput("m_msg_cnt", MSG_W'(out_msg_cnt), MSG_W'(m_cnt));
        fire   = (q_msg.size() != 0) && bus.out_ready;
        accept = bus.in_valid && exp_ready;
        if (fire) begin
          void'(q_msg.pop_front());
          void'(q_lane.pop_front());
          m_cnt = m_cnt + 32'd1;
        end
        if (accept) begin
          if (bus.in_lane_vld[0]) begin q_msg.push_back(bus.message_1); q_lane.push_back(2'd1); end
          if (bus.in_lane_vld[1]) begin q_msg.push_back(bus.message_2); q_lane.push_back(2'd2); end
          if (bus.in_lane_vld[2]) begin q_msg.push_back(bus.message_3); q_lane.push_back(2'd3); end
          if (bus.in_lane_vld[2])      {m_pid, m_mc, m_mt} = bus.message_3[279:256];
          else if (bus.in_lane_vld[1]) {m_pid, m_mc, m_mt} = bus.message_2[279:256];
          else if (bus.in_lane_vld[0]) {m_pid, m_mc, m_mt} = bus.message_1[279:256];
        end
        if (dict_clr) {m_pid, m_mc, m_mt} = 24'h0;
      end
    end
  end

  initial begin
    logic [MSG_W-1:0] a1, a2, a3, b1, c1, c2, c3, d1;
    logic holding;
    int waited;

    applyStimulus(1'b0, 3'b000, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    #17 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_pid1", MSG_W'(field_PID1), MSG_W'(8'h00));
    checkOutput("rst_mc1", MSG_W'(field_MC1), MSG_W'(8'h00));
    checkOutput("rst_mt1", MSG_W'(field_MT1), MSG_W'(8'h00));
    checkOutput("rst_out_valid", MSG_W'(bus.out_valid), MSG_W'(0));
    checkOutput("rst_in_ready", MSG_W'(bus.in_ready), MSG_W'(1));
    checkOutput("rst_cnt", MSG_W'(out_msg_cnt), MSG_W'(0));
    @(posedge clk); #1;

    // Full bundle, then a second one that must land on the third output cycle
    a1 = mk(8'h11, 8'h01, 8'h02); a2 = mk(8'h22, 8'h03, 8'h04); a3 = mk(8'h33, 8'h05, 8'h06);
    b1 = mk(8'h44, 8'h07, 8'h08);
    sendBundle(3'b111, a1, a2, a3, 1'b0, waited);
    @(negedge clk);
    checkOutput("full_lane1", MSG_W'(bus.out_lane), MSG_W'(2'd1));
    checkOutput("full_msg1", bus.out_message, a1);
    checkOutput("full_pid1", MSG_W'(field_PID1), MSG_W'(8'h33));
    @(posedge clk); #1;
    sendBundle(3'b001, b1, a2, a3, 1'b0, waited);
    checkOutput("b2b_wait_cycles", MSG_W'(waited), MSG_W'(2));
    @(negedge clk);
    checkOutput("b2b_lane", MSG_W'(bus.out_lane), MSG_W'(2'd1));
    checkOutput("b2b_msg", bus.out_message, b1);
    checkOutput("b2b_cnt", MSG_W'(out_msg_cnt), MSG_W'(3));
    checkOutput("b2b_pid1", MSG_W'(field_PID1), MSG_W'(8'h44));
    @(posedge clk); #1;
    waitIdle();

    // Sparse bundle under backpressure
    c1 = mk(8'hAA, 8'h10, 8'h11); c2 = mk(8'hBB, 8'h12, 8'h13); c3 = mk(8'hCC, 8'h14, 8'h15);
    bus.out_ready = 1'b0;
    sendBundle(3'b101, c1, c2, c3, 1'b0, waited);
    @(negedge clk);
    checkOutput("stall_lane_a", MSG_W'(bus.out_lane), MSG_W'(2'd1));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("stall_lane_b", MSG_W'(bus.out_lane), MSG_W'(2'd1));
    checkOutput("stall_msg_b", bus.out_message, c1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_msg_c", bus.out_message, c1);
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("sparse_lane3", MSG_W'(bus.out_lane), MSG_W'(2'd3));
    checkOutput("sparse_msg3", bus.out_message, c3);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("sparse_done_valid", MSG_W'(bus.out_valid), MSG_W'(0));
    checkOutput("sparse_cnt", MSG_W'(out_msg_cnt), MSG_W'(6));
    checkOutput("sparse_pid1", MSG_W'(field_PID1), MSG_W'(8'hCC));
    @(posedge clk); #1;

    // Empty bundle: no output, dictionary untouched
    sendBundle(3'b000, mk(8'hDD, 8'h0, 8'h0), c2, c3, 1'b0, waited);
    @(negedge clk);
    checkOutput("empty_valid", MSG_W'(bus.out_valid), MSG_W'(0));
    checkOutput("empty_ready", MSG_W'(bus.in_ready), MSG_W'(1));
    checkOutput("empty_pid1", MSG_W'(field_PID1), MSG_W'(8'hCC));
    @(posedge clk); #1;

    // Clear coincident with an accept
    d1 = mk(8'h5A, 8'h5B, 8'h5C);
    sendBundle(3'b001, d1, c2, c3, 1'b1, waited);
    @(negedge clk);
    checkOutput("clr_pid1", MSG_W'(field_PID1), MSG_W'(8'h00));
    checkOutput("clr_mc1", MSG_W'(field_MC1), MSG_W'(8'h00));
    checkOutput("clr_msg", bus.out_message, d1);
    @(posedge clk); #1;
    waitIdle();

    // Counter wrap
    force dut.out_msg_cnt = 32'hFFFF_FFFF;
    #1 release dut.out_msg_cnt;
    m_cnt = 32'hFFFF_FFFF;
    sendBundle(3'b001, d1, c2, c3, 1'b0, waited);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("cnt_wrap", MSG_W'(out_msg_cnt), MSG_W'(0));
    @(posedge clk); #1;

    // Async reset in the middle of a drain
    sendBundle(3'b111, a1, a2, a3, 1'b0, waited);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("areset_valid", MSG_W'(bus.out_valid), MSG_W'(0));
    checkOutput("areset_lane", MSG_W'(bus.out_lane), MSG_W'(0));
    checkOutput("areset_pid1", MSG_W'(field_PID1), MSG_W'(8'h00));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized bundles, lane masks, clears and backpressure
    holding = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!holding) begin
        applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))),
                      mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))),
                      mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))),
                      1'b0);
      end
      dict_clr = ($urandom_range(0, 7) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      holding = bus.in_valid && !bus.in_ready;
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 3'b000, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    waitIdle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
